// File: rtl/sent_rx_pkg.sv
// Shared types and constants for the SENT receive front-end.
package sent_rx_pkg;
  localparam int CNT_WIDTH_DEFAULT = 16;
  localparam int SENT_LOW_MIN      = 4;

  typedef enum logic {IDLE, MEASURE} state_t;
endpackage

// File: rtl/sent_rx_edge_capture_filter.sv
// Two-flop synchroniser plus FILT_LEN-sample glitch filter (module sent_rx_glitch_filter).
// Produces the filtered level and registered single-cycle fall/rise strobes.
module sent_rx_glitch_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_rx,
  input  logic reset_n_rx,
  input  logic sent_rx_i,
  output logic level,
  output logic fall,
  output logic rise
);
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] LAST = FW'(FILT_LEN - 1);
  localparam logic [FW-1:0] ONE  = FW'(1);

  logic          sync_p0, sync_p1;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          level_d;

  always_comb begin
    level_d = level;
    cnt_d   = '0;
    if (sync_p1 != level) begin
      if (cnt_q == LAST) level_d = ~level;
      else               cnt_d   = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt_q   <= '0;
      level   <= 1'b1;
      fall    <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= sent_rx_i;
      // synchroniser -> filter stage boundary
      sync_p1 <= sync_p0;
      cnt_q   <= cnt_d;
      level   <= level_d;
      fall    <= level & ~level_d;
      rise    <= ~level & level_d;
    end
  end
endmodule

// File: rtl/sent_rx_edge_capture.sv
// SENT receive front-end: filtered falling-edge period measurement, sync-window flag, idle timeout.
// Optional low-phase width check enabled by defining SENT_RX_LOW_TIME_CHECK_EN.
module sent_rx_edge_capture
  import sent_rx_pkg::*;
#(
  parameter int                   CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int                   FILT_LEN  = 3,
  parameter logic [CNT_WIDTH-1:0] SYNC_MIN  = CNT_WIDTH'(50),
  parameter logic [CNT_WIDTH-1:0] SYNC_MAX  = CNT_WIDTH'(62),
  parameter logic [CNT_WIDTH-1:0] TIMEOUT   = CNT_WIDTH'(4000)
) (
  input  logic                 clk_rx,
  input  logic                 reset_n_rx,
  input  logic                 sent_rx_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  output logic                 sync_flag_o,
  output logic                 timeout_o,
  output logic                 line_level_o,
  output logic                 low_err_o
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic in_sync_window(input logic [CNT_WIDTH-1:0] p);
    return (p >= SYNC_MIN) && (p <= SYNC_MAX);
  endfunction

  logic level, fall, rise;

  sent_rx_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk_rx     (clk_rx),
    .reset_n_rx (reset_n_rx),
    .sent_rx_i  (sent_rx_i),
    .level      (level),
    .fall       (fall),
    .rise       (rise)
  );

  assign line_level_o = level;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 emit, expire;

  // A fall on the same cycle the counter hits TIMEOUT still yields a period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (fall) begin
          emit  = 1'b1;
          cnt_d = CNT_ONE;
        end else if (cnt_q == TIMEOUT) begin
          expire  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      sync_flag_o    <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      // measurement -> output register stage boundary
      period_valid_o <= emit;
      timeout_o      <= expire;
      if (emit) begin
        period_o    <= cnt_q;
        sync_flag_o <= in_sync_window(cnt_q);
      end
    end
  end

`ifdef SENT_RX_LOW_TIME_CHECK_EN
  logic [2:0] low_cnt_q;

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      low_cnt_q <= '0;
      low_err_o <= 1'b0;
    end else begin
      low_err_o <= rise && (low_cnt_q < 3'(SENT_LOW_MIN));
      if (fall)                          low_cnt_q <= 3'd1;
      else if (!level && low_cnt_q != 3'd7) low_cnt_q <= low_cnt_q + 3'd1;
    end
  end
`else
  logic unused_rise;
  assign unused_rise = rise;
  assign low_err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_sent_rx_edge_capture.sv
// Directed bench for sent_rx_edge_capture (default parameters, FILT_LEN=3, TIMEOUT=4000).
module tb_sent_rx_edge_capture;
  localparam int TIMEOUT = 4000;

  logic        clk_rx = 1'b0;
  logic        reset_n_rx;
  logic        sent_rx_i;
  logic [15:0] period_o;
  logic        period_valid_o, sync_flag_o, timeout_o, line_level_o, low_err_o;

  sent_rx_edge_capture dut (
    .clk_rx         (clk_rx),
    .reset_n_rx     (reset_n_rx),
    .sent_rx_i      (sent_rx_i),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .sync_flag_o    (sync_flag_o),
    .timeout_o      (timeout_o),
    .line_level_o   (line_level_o),
    .low_err_o      (low_err_o)
  );

  always #5 clk_rx = ~clk_rx;

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, n_valid = 0, n_to = 0, n_lfall = 0, n_lerr = 0, n_both = 0;
  int   last_valid_cyc = 0, last_to_cyc = 0;
  logic prev_level = 1'b1;

  // Event log sampled mid-cycle.
  always @(negedge clk_rx) begin
    cyc        <= cyc + 1;
    prev_level <= line_level_o;
    if (period_valid_o) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (timeout_o) begin
      n_to        <= n_to + 1;
      last_to_cyc <= cyc;
    end
    if (period_valid_o && timeout_o) n_both <= n_both + 1;
    if (prev_level && !line_level_o) n_lfall <= n_lfall + 1;
    if (low_err_o) n_lerr <= n_lerr + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    sent_rx_i = v;
    repeat (n) @(posedge clk_rx);
    #1;
  endtask

  task automatic frame(input int p, input int low);
    drive(1'b0, low);
    drive(1'b1, p - low);
  endtask

  int tbl[6]      = '{24, 49, 63, 50, 62, 56};
  int exp_sync[5] = '{0, 0, 0, 1, 1};
  int v0, f0, t0, lv0, le0;

  initial begin
    reset_n_rx = 1'b0;
    sent_rx_i  = 1'b1;
    repeat (3) @(posedge clk_rx);
    #1;
    check("rst_period", period_o, 0);
    check("rst_valid", period_valid_o, 0);
    check("rst_sync", sync_flag_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_level", line_level_o, 1);
    check("rst_low_err", low_err_o, 0);
    reset_n_rx = 1'b1;

    // Idle line: nothing happens
    drive(1'b1, 10000);
    check("idle_valid_cnt", n_valid, 0);
    check("idle_timeout_cnt", n_to, 0);
    check("idle_level", line_level_o, 1);
    check("idle_level_falls", n_lfall, 0);

    // 56-cycle frames: first fall only opens the window
    v0 = n_valid;
    for (int i = 0; i < 4; i++) begin
      frame(56, 10);
      check("f56_valid_cnt", n_valid, v0 + i);
      if (i > 0) begin
        check("f56_period", period_o, 56);
        check("f56_sync", sync_flag_o, 1);
      end
    end

    // Sync window boundaries; each fall reports the preceding frame length
    frame(tbl[0], 10);
    for (int k = 1; k < 6; k++) begin
      frame(tbl[k], 10);
      check("win_period", period_o, tbl[k-1]);
      check("win_sync", sync_flag_o, exp_sync[k-1]);
    end

    // 2-cycle low glitch inside a high phase
    v0 = n_valid;
    f0 = n_lfall;
    drive(1'b0, 10);
    drive(1'b1, 20);
    drive(1'b0, 2);
    drive(1'b1, 24);
    frame(56, 10);
    check("glitch_valid_cnt", n_valid, v0 + 2);
    check("glitch_period", period_o, 56);
    check("glitch_level_falls", n_lfall, f0 + 2);

    // Idle timeout after last fall
    check("no_early_timeout", n_to, 0);
    v0  = n_valid;
    t0  = n_to;
    lv0 = last_valid_cyc;
    for (int i = 0; i < TIMEOUT + 100 && n_to == t0; i++) begin
      @(posedge clk_rx);
      #1;
    end
    repeat (100) @(posedge clk_rx);
    #1;
    check("to_count", n_to, t0 + 1);
    check("to_distance", last_to_cyc - lv0, TIMEOUT);
    check("to_period_kept", period_o, 56);
    check("to_no_valid", n_valid, v0);
    frame(56, 10);
    check("to_first_fall_silent", n_valid, v0);
    frame(56, 10);
    check("to_resume_valid", n_valid, v0 + 1);
    check("to_resume_period", period_o, 56);

    // Fall coincident with counter == TIMEOUT
    frame(TIMEOUT, 10);
    frame(56, 10);
    check("edge_to_period", period_o, TIMEOUT);
    check("edge_to_sync", sync_flag_o, 0);
    check("edge_to_no_timeout", n_to, t0 + 1);

    // Reset mid-measurement
    drive(1'b0, 10);
    drive(1'b1, 20);
    reset_n_rx = 1'b0;
    repeat (3) @(posedge clk_rx);
    #1;
    check("mid_rst_period", period_o, 0);
    check("mid_rst_level", line_level_o, 1);
    reset_n_rx = 1'b1;
    drive(1'b1, 26);
    v0 = n_valid;
    frame(56, 10);
    check("post_rst_silent", n_valid, v0);
    frame(56, 10);
    check("post_rst_valid", n_valid, v0 + 1);
    check("post_rst_period", period_o, 56);
    check("post_rst_sync", sync_flag_o, 1);

    // Short 3-cycle low phase
    le0 = n_lerr;
    frame(56, 3);
    frame(56, 10);
    check("short_low_period", period_o, 56);
`ifdef SENT_RX_LOW_TIME_CHECK_EN
    check("short_low_err", n_lerr, le0 + 1);
`else
    check("short_low_err", n_lerr, le0);
`endif
    check("valid_timeout_overlap", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
